pll_reset_supervisor: RTL and testbench

- Sits beside the processor clock PLL and consumes its `locked` flag and a sampled copy of its output clock.
- Drives the PLL's reset and holds the processor-domain reset asserted until the PLL is locked, runs at the right frequency, and has stayed stable.
- On lock loss or a bad measurement it re-sequences the PLL automatically; after repeated consecutive failures it declares a sticky fault.

---
 rtl/pll_reset_supervisor_if.sv | 34 +++
 rtl/pll_reset_supervisor.sv | 231 +++++++++++++++++++++++
 tb/tb_pll_reset_supervisor.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_supervisor_if.sv
// Signal bundle between the PLL reset supervisor and its PLL / processor-domain neighbours.
// master = supervisor side, slave = PLL model and reset consumer side.
interface pll_reset_supervisor_if;
    logic        locked;
    logic        outclk_sense;
    logic        pll_rst;
    logic        proc_rst;
    logic        ready;
    logic        fault;
    logic [3:0]  retry_count;
    logic [15:0] edge_count;

    modport master (
        input  locked,
        input  outclk_sense,
        output pll_rst,
        output proc_rst,
        output ready,
        output fault,
        output retry_count,
        output edge_count
    );

    modport slave (
        output locked,
        output outclk_sense,
        input  pll_rst,
        input  proc_rst,
        input  ready,
        input  fault,
        input  retry_count,
        input  edge_count
    );
endinterface

// File: rtl/pll_reset_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for lock, optionally checks output frequency, holds, then releases proc_rst.
// Frequency measurement (MEAS state) is compiled in only when PLLSUP_FREQ_CHECK_EN is defined.
module pll_reset_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int WINDOW_CYCLES  = 1000,
    parameter int EXPECTED_EDGES = 100,
    parameter int EDGE_TOL       = 2,
    parameter int HOLD_CYCLES    = 256,
    parameter int RETRY_MAX      = 3
) (
    input  logic                   refclk,
    input  logic                   rst,
    pll_reset_supervisor_if.master sup
);

    localparam int M1      = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int M2      = (WINDOW_CYCLES > HOLD_CYCLES) ? WINDOW_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RC_W    = $clog2(RETRY_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_LIMIT  = RC_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_MEAS   = 3'd2,
        S_HOLD   = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  consec_q, consec_d;
    logic [3:0]       retry_count_q, retry_count_d;
    logic             pll_rst_q, pll_rst_d;
    logic             proc_rst_q, proc_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             locked_meta_q, locked_s_q;
    logic             fail_evt;

    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
        end else begin
            locked_meta_q <= sup.locked;
            locked_s_q    <= locked_meta_q;
        end
    end

`ifdef PLLSUP_FREQ_CHECK_EN
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [15:0]      EXP_E    = 16'(EXPECTED_EDGES);
    localparam logic [15:0]      TOL_E    = 16'(EDGE_TOL);

    logic        clk_meta_q, clk_s_q, clk_dly_q;
    logic [15:0] edges_q, edges_d;
    logic [15:0] edge_count_q, edge_count_d;
    logic        rise;
    logic [15:0] edges_inc;
    logic [15:0] dev;
    logic        in_tol;

    always_ff @(posedge refclk) begin
        if (rst) begin
            clk_meta_q   <= 1'b0;
            clk_s_q      <= 1'b0;
            clk_dly_q    <= 1'b0;
            edges_q      <= '0;
            edge_count_q <= '0;
        end else begin
            clk_meta_q   <= sup.outclk_sense;
            clk_s_q      <= clk_meta_q;
            clk_dly_q    <= clk_s_q;
            edges_q      <= edges_d;
            edge_count_q <= edge_count_d;
        end
    end

    // edges_inc already includes this cycle's edge, so the window's last cycle is counted
    always_comb begin
        rise      = clk_s_q & ~clk_dly_q;
        edges_inc = edges_q;
        if (rise && (edges_q != 16'hFFFF)) begin
            edges_inc = edges_q + 16'd1;
        end
        if (edges_inc >= EXP_E) begin
            dev = edges_inc - EXP_E;
        end else begin
            dev = EXP_E - edges_inc;
        end
        in_tol = (dev <= TOL_E);
    end
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        consec_d      = consec_q;
        retry_count_d = retry_count_q;
        fail_evt      = 1'b0;
`ifdef PLLSUP_FREQ_CHECK_EN
        edges_d       = edges_q;
        edge_count_d  = edge_count_q;
`endif
        case (state_q)
            S_PLLRST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (locked_s_q) begin
`ifdef PLLSUP_FREQ_CHECK_EN
                    state_d = S_MEAS;
`else
                    state_d = S_HOLD;
`endif
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fail_evt = 1'b1;
                end
            end
`ifdef PLLSUP_FREQ_CHECK_EN
            S_MEAS: begin
                cnt_d   = cnt_q + 1'b1;
                edges_d = edges_inc;
                if (cnt_q == WIN_LAST) begin
                    edge_count_d = edges_inc;
                    if (locked_s_q && in_tol) begin
                        state_d = S_HOLD;
                    end else begin
                        fail_evt = 1'b1;
                    end
                end else if (!locked_s_q) begin
                    fail_evt = 1'b1;
                end
            end
`endif
            S_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (!locked_s_q) begin
                    fail_evt = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d  = S_RUN;
                    consec_d = '0;
                end
            end
            S_RUN: begin
                if (!locked_s_q) begin
                    fail_evt = 1'b1;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_PLLRST;
            end
        endcase

        if (fail_evt) begin
            if (retry_count_q != 4'hF) begin
                retry_count_d = retry_count_q + 4'd1;
            end
            consec_d = consec_q + 1'b1;
            state_d  = (consec_d == RETRY_LIMIT) ? S_FAULT : S_PLLRST;
        end

        // every state entry starts its own cycle/edge count from zero
        if (state_d != state_q) begin
            cnt_d = '0;
`ifdef PLLSUP_FREQ_CHECK_EN
            edges_d = '0;
`endif
        end
    end

    // outputs are decoded from the next state so they change on the same edge as the state
    always_comb begin
        pll_rst_d  = (state_d == S_PLLRST) || (state_d == S_FAULT);
        proc_rst_d = (state_d != S_RUN);
        ready_d    = (state_d == S_RUN);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= S_PLLRST;
            cnt_q         <= '0;
            consec_q      <= '0;
            retry_count_q <= '0;
            pll_rst_q     <= 1'b1;
            proc_rst_q    <= 1'b1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            consec_q      <= consec_d;
            retry_count_q <= retry_count_d;
            pll_rst_q     <= pll_rst_d;
            proc_rst_q    <= proc_rst_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    assign sup.pll_rst     = pll_rst_q;
    assign sup.proc_rst    = proc_rst_q;
    assign sup.ready       = ready_q;
    assign sup.fault       = fault_q;
    assign sup.retry_count = retry_count_q;

`ifdef PLLSUP_FREQ_CHECK_EN
    assign sup.edge_count = edge_count_q;
`else
    logic unused_cfg;
    assign sup.edge_count = '0;
    assign unused_cfg     = ^{sup.outclk_sense, 32'(EXPECTED_EDGES), 32'(EDGE_TOL)};
`endif

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed bench for pll_reset_supervisor; cycle 0 is the first cycle after the last edge that sampled rst high.
// Expectations follow PLLSUP_FREQ_CHECK_EN when the bench is built with it.
module tb_pll_reset_supervisor;

`ifdef PLLSUP_FREQ_CHECK_EN
    localparam int          MEAS_LAT  = 100;
    localparam logic [15:0] NOM_EDGES = 16'd10;
`else
    localparam int          MEAS_LAT  = 0;
    localparam logic [15:0] NOM_EDGES = 16'd0;
`endif
    // locked high at cycle 10 -> locked_s at 12 -> leave WAIT at 13 -> window -> 20-cycle hold
    localparam int T_REL  = 33 + MEAS_LAT;
    localparam int HOLD_0 = 13 + MEAS_LAT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   c       = 0;
    int   period  = 10;

    pll_reset_supervisor_if bus ();

    pll_reset_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (200),
        .WINDOW_CYCLES (100),
        .EXPECTED_EDGES(10),
        .EDGE_TOL      (1),
        .HOLD_CYCLES   (20),
        .RETRY_MAX     (3)
    ) dut (
        .refclk(clk),
        .rst   (rst),
        .sup   (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        bus.outclk_sense = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ph++;
            bus.outclk_sense = ((ph % period) < (period / 2));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", c);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic run_to(input int target);
        while (c < target) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        c = 0;
    endtask

    task automatic test_reset();
        bus.locked = 1'b0;
        do_reset();
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b expected 1", bus.pll_rst); end
        n_tests++; if (bus.proc_rst !== 1'b1) begin n_fail++; $display("FAIL reset_proc_rst: got %b expected 1", bus.proc_rst); end
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
        n_tests++; if (bus.retry_count !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", bus.retry_count); end
        n_tests++; if (bus.edge_count !== 16'd0) begin n_fail++; $display("FAIL reset_edge_count: got %0d expected 0", bus.edge_count); end
        $display("[TB] reset: outputs at reset values checked");
    endtask

    task automatic test_nominal();
        int rel;
        rel = -1;
        period = 10;
        bus.locked = 1'b0;
        do_reset();
        while (c < 140) begin
            if (c == 10) bus.locked = 1'b1;
            if (rel < 0 && bus.proc_rst === 1'b0) rel = c;
            n_tests++;
            if (bus.pll_rst !== (c <= 3)) begin
                n_fail++; $display("FAIL nominal_pll_rst c=%0d: got %b expected %b", c, bus.pll_rst, (c <= 3));
            end
            n_tests++;
            if (bus.proc_rst !== (c < T_REL)) begin
                n_fail++; $display("FAIL nominal_proc_rst c=%0d: got %b expected %b", c, bus.proc_rst, (c < T_REL));
            end
            tick();
        end
        n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL nominal_ready: got %b expected 1", bus.ready); end
        n_tests++; if (bus.retry_count !== 4'd0) begin n_fail++; $display("FAIL nominal_retry: got %0d expected 0", bus.retry_count); end
        n_tests++; if (bus.edge_count !== NOM_EDGES) begin n_fail++; $display("FAIL nominal_edge_count: got %0d expected %0d", bus.edge_count, NOM_EDGES); end
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL nominal_fault: got %b expected 0", bus.fault); end
        $display("[TB] nominal: proc_rst released at cycle %0d, edge_count %0d", rel, bus.edge_count);
    endtask

    task automatic test_lock_loss();
        int j;
        j = c;
        bus.locked = 1'b0;
        tick();
        n_tests++; if (bus.proc_rst !== 1'b0) begin n_fail++; $display("FAIL loss_early_j1: proc_rst got %b expected 0", bus.proc_rst); end
        tick();
        n_tests++; if (bus.proc_rst !== 1'b0) begin n_fail++; $display("FAIL loss_early_j2: proc_rst got %b expected 0", bus.proc_rst); end
        tick();
        n_tests++; if (bus.proc_rst !== 1'b1) begin n_fail++; $display("FAIL loss_proc_rst: got %b expected 1", bus.proc_rst); end
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready: got %b expected 0", bus.ready); end
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_pll_rst: got %b expected 1", bus.pll_rst); end
        n_tests++; if (bus.retry_count !== 4'd1) begin n_fail++; $display("FAIL loss_retry: got %0d expected 1", bus.retry_count); end
        run_to(j + 10);
        bus.locked = 1'b1;
        while (bus.ready !== 1'b1 && c < j + 400) tick();
        n_tests++;
        if (c != j + 33 + MEAS_LAT) begin
            n_fail++; $display("FAIL loss_relock_cycle: ready at cycle %0d expected %0d", c, j + 33 + MEAS_LAT);
        end
        n_tests++; if (bus.retry_count !== 4'd1) begin n_fail++; $display("FAIL loss_relock_retry: got %0d expected 1", bus.retry_count); end
        n_tests++; if (bus.edge_count !== NOM_EDGES) begin n_fail++; $display("FAIL loss_relock_edges: got %0d expected %0d", bus.edge_count, NOM_EDGES); end
        $display("[TB] lock_loss: dropped at %0d, ready again at %0d", j, c);
    endtask

    task automatic test_glitch_hold();
        int g;
        g = HOLD_0 + 5;
        period = 10;
        bus.locked = 1'b0;
        do_reset();
        while (c < g + 3) begin
            if (c == 10) bus.locked = 1'b1;
            if (c == g) bus.locked = 1'b0;
            n_tests++;
            if (bus.proc_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_proc_rst c=%0d: got %b expected 1", c, bus.proc_rst); end
            if (c == g + 2) begin
                bus.locked = 1'b1;
                n_tests++;
                if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL glitch_still_hold: pll_rst got %b expected 0", bus.pll_rst); end
            end
            tick();
        end
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_pll_rst: got %b expected 1", bus.pll_rst); end
        n_tests++; if (bus.retry_count !== 4'd1) begin n_fail++; $display("FAIL glitch_retry: got %0d expected 1", bus.retry_count); end
        n_tests++; if (bus.proc_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_proc_after: got %b expected 1", bus.proc_rst); end
        $display("[TB] glitch_hold: 2-cycle drop at %0d, back to PLLRST at %0d", g, c);
    endtask

    task automatic test_no_lock();
        bus.locked = 1'b0;
        do_reset();
        run_to(203);
        n_tests++; if (bus.retry_count !== 4'd0) begin n_fail++; $display("FAIL nolock_retry_203: got %0d expected 0", bus.retry_count); end
        n_tests++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL nolock_pll_rst_203: got %b expected 0", bus.pll_rst); end
        tick();
        n_tests++; if (bus.retry_count !== 4'd1) begin n_fail++; $display("FAIL nolock_retry_204: got %0d expected 1", bus.retry_count); end
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL nolock_pll_rst_204: got %b expected 1", bus.pll_rst); end
        run_to(408);
        n_tests++; if (bus.retry_count !== 4'd2) begin n_fail++; $display("FAIL nolock_retry_408: got %0d expected 2", bus.retry_count); end
        run_to(611);
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL nolock_fault_611: got %b expected 0", bus.fault); end
        tick();
        n_tests++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL nolock_fault_612: got %b expected 1", bus.fault); end
        n_tests++; if (bus.retry_count !== 4'd3) begin n_fail++; $display("FAIL nolock_retry_612: got %0d expected 3", bus.retry_count); end
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL nolock_pll_rst_612: got %b expected 1", bus.pll_rst); end
        n_tests++; if (bus.proc_rst !== 1'b1) begin n_fail++; $display("FAIL nolock_proc_rst_612: got %b expected 1", bus.proc_rst); end
        bus.locked = 1'b1;
        run_to(700);
        n_tests++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b expected 1", bus.fault); end
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL fault_ready: got %b expected 0", bus.ready); end
        n_tests++; if (bus.retry_count !== 4'd3) begin n_fail++; $display("FAIL fault_retry: got %0d expected 3", bus.retry_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL fault_rst_fault: got %b expected 0", bus.fault); end
        n_tests++; if (bus.retry_count !== 4'd0) begin n_fail++; $display("FAIL fault_rst_retry: got %0d expected 0", bus.retry_count); end
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL fault_rst_pll_rst: got %b expected 1", bus.pll_rst); end
        $display("[TB] no_lock: fault after three timeouts, cleared by rst");
    endtask

`ifdef PLLSUP_FREQ_CHECK_EN
    task automatic test_wrong_freq();
        period = 8;
        bus.locked = 1'b0;
        do_reset();
        while (c < 112) begin
            if (c == 10) bus.locked = 1'b1;
            tick();
        end
        n_tests++; if (bus.edge_count !== 16'd0) begin n_fail++; $display("FAIL freq_edges_early: got %0d expected 0", bus.edge_count); end
        n_tests++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL freq_pll_rst_112: got %b expected 0", bus.pll_rst); end
        tick();
        n_tests++;
        if (bus.edge_count !== 16'd12 && bus.edge_count !== 16'd13) begin
            n_fail++; $display("FAIL freq_edges: got %0d expected 12 or 13", bus.edge_count);
        end
        n_tests++; if (bus.retry_count !== 4'd1) begin n_fail++; $display("FAIL freq_retry: got %0d expected 1", bus.retry_count); end
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL freq_pll_rst_113: got %b expected 1", bus.pll_rst); end
        n_tests++; if (bus.proc_rst !== 1'b1) begin n_fail++; $display("FAIL freq_proc_rst: got %b expected 1", bus.proc_rst); end
        run_to(116);
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL freq_pll_rst_116: got %b expected 1", bus.pll_rst); end
        tick();
        n_tests++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL freq_pll_rst_117: got %b expected 0", bus.pll_rst); end
        $display("[TB] wrong_freq: period 8 measured %0d edges, retry %0d", bus.edge_count, bus.retry_count);
    endtask
`endif

    task automatic test_reset_mid_meas();
`ifdef PLLSUP_FREQ_CHECK_EN
        // continues from the failed period-8 window; a second window runs from cycle 118
        run_to(130);
        n_tests++; if (bus.edge_count === 16'd0) begin n_fail++; $display("FAIL midrst_pre_edges: got %0d expected nonzero", bus.edge_count); end
`else
        period = 10;
        bus.locked = 1'b0;
        do_reset();
        while (c < 40) begin
            if (c == 10) bus.locked = 1'b1;
            if (c == 20) bus.locked = 1'b0;
            if (c == 22) bus.locked = 1'b1;
            tick();
        end
`endif
        n_tests++; if (bus.retry_count !== 4'd1) begin n_fail++; $display("FAIL midrst_pre_retry: got %0d expected 1", bus.retry_count); end
        rst = 1'b1;
        tick();
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_pll_rst: got %b expected 1", bus.pll_rst); end
        n_tests++; if (bus.proc_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_proc_rst: got %b expected 1", bus.proc_rst); end
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", bus.ready); end
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL midrst_fault: got %b expected 0", bus.fault); end
        n_tests++; if (bus.retry_count !== 4'd0) begin n_fail++; $display("FAIL midrst_retry: got %0d expected 0", bus.retry_count); end
        n_tests++; if (bus.edge_count !== 16'd0) begin n_fail++; $display("FAIL midrst_edges: got %0d expected 0", bus.edge_count); end
        rst = 1'b0;
        $display("[TB] reset_mid_meas: rst pulse returned outputs to reset values");
    endtask

    initial begin
        bus.locked = 1'b0;
        test_reset();
        test_nominal();
        test_lock_loss();
        test_glitch_hold();
        test_no_lock();
`ifdef PLLSUP_FREQ_CHECK_EN
        test_wrong_freq();
`endif
        test_reset_mid_meas();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
